// File: rtl/booth4_mul.sv
// Iterative radix-4 Booth multiplier with valid/ready on both sides.
// Retires two multiplier bits per cycle; signed or unsigned selected per operation.
module booth4_mul #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          ZERO_SKIP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned EW = WIDTH + 2;
    localparam int unsigned AW = WIDTH + 3;
    localparam int unsigned N  = WIDTH / 2 + 1;
    localparam int unsigned CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [EW:0]        mul_q, mul_d;
    logic [EW-1:0]      mcand_q, mcand_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_d;
    logic               out_valid_d;

    logic [EW-1:0]      a_ext, b_ext;
    logic [2:0]         sel;
    logic               neg, two, zero_t;
    logic [AW-1:0]      mag, term, sum, acc_step;
    logic [EW:0]        mul_step;
    logic [2*WIDTH-1:0] prod_lo;

    assign in_ready = (state_q == S_IDLE) && !rst;

    // Operand extension by two bits keeps unsigned max*max exact.
    always_comb begin
        a_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
        b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    end

    // One Booth step: select 0/+-X/+-2X, add with inversion+carry-in, shift pair right by 2.
    always_comb begin
        sel      = mul_q[2:0];
        neg      = sel[2] & ~(sel[1] & sel[0]);
        two      = (sel == 3'b011) || (sel == 3'b100);
        zero_t   = (sel == 3'b000) || (sel == 3'b111);
        mag      = zero_t ? '0 : (two ? {mcand_q, 1'b0} : {mcand_q[EW-1], mcand_q});
        term     = neg ? ~mag : mag;
        sum      = acc_q + term + AW'(neg);
        acc_step = {{2{sum[AW-1]}}, sum[AW-1:2]};
        mul_step = {sum[1:0], mul_q[EW:2]};
        prod_lo  = {acc_step[WIDTH-3:0], mul_step[EW:1]};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mul_d    = mul_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        result_d = result;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    mcand_d = a_ext;
                    mul_d   = {b_ext, 1'b0};
                    acc_d   = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = S_CALC;
                    if (ZERO_SKIP && ((a == '0) || (b == '0))) begin
                        state_d  = S_DONE;
                        result_d = '0;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                mul_d = mul_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = prod_lo;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mul_q     <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mul_q     <= mul_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            result    <= result_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: doc/booth4_mul.md
Name: booth4_mul

Overview:
Iterative radix-4 Booth multiplier, the parametrised successor to the team's radix-2 sequential multiplier. It retires two multiplier bits per cycle and supports signed and unsigned operands, selected per operation. It uses a full valid/ready handshake on both input and output, so it can sit behind a pipeline stage that may stall. It is intended for the DNN datapath and ALU mul/mulh paths.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 4.
ZERO_SKIP, 1, when 1 a zero operand bypasses iteration and completes in 1 cycle.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand pair offered
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = both operands two's complement, 0 = both unsigned
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
result  output  2*WIDTH  product, held stable while out_valid=1

Behaviour:
- One clock; reset is synchronous and active-high. With rst=1 at an edge: state<=IDLE, result<=0, out_valid=0, counter<=0. in_ready=0 while rst is high.
- Reset mid-operation aborts the operation with no output; the next accept is normal.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1 and out_valid=0.
  - Accept when in_valid&&in_ready. Latch a and b, extended to WIDTH+2 bits: sign-extended if is_signed=1, zero-extended otherwise.
  - Load the accumulator with 0, the multiplier with an appended 0 LSB, and cnt=N-1, where N=WIDTH/2+1.
  - Go to CALC. If ZERO_SKIP=1 and (a==0 or b==0), go directly to DONE with result=0.
- CALC:
  - in_ready=0 and out_valid=0.
  - Each cycle, examine multiplier bits {b[2i+1],b[2i],b[2i-1]} and select 0, +X, +2X, -X or -2X per the standard radix-4 Booth table.
  - Add the selected term to the upper accumulator at WIDTH+3 bits. Shift the accumulator/multiplier pair arithmetically right by 2. Decrement cnt.
  - When cnt==0, the step just performed is the last; go to DONE.
  - -X and -2X use inversion plus carry-in; no separate subtractor.
- DONE:
  - out_valid=1 and result = low 2*WIDTH bits of the product.
  - result is stable until out_valid&&out_ready.
  - On handshake go to IDLE. A new accept is possible at the earliest on the next cycle; no overlap.
- Latency:
  - Accept at edge t: out_valid is first high in the cycle after edge t+N, i.e. N+1 cycles after accept (18 for WIDTH=32).
  - Zero-skip: out_valid is high in the cycle after edge t.
- Arithmetic:
  - Result is exact modulo 2^(2*WIDTH) for all operand values, including most-negative x most-negative in signed mode.
  - The unsigned max x max case needs the WIDTH+2 extension; this is mandatory.
- is_signed, a and b are sampled only at accept; later changes are ignored.
- Backpressure: out_ready may stay low indefinitely; the block holds in DONE with in_ready=0.
- in_valid while busy is ignored, not queued; the producer must hold it until in_ready.

Test Plan:
- WIDTH=32, is_signed=1, a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready=1 -> result=0x0000000000000001; out_valid is first high 18 cycles after accept.
- WIDTH=32, is_signed=0, a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE00000001.
- is_signed=1:
  - a=0x80000000, b=0x80000000 -> result=0x4000000000000000.
  - a=0xFFFFFFFD (-3), b=5 -> result=0xFFFFFFFFFFFFFFF1.
- Zero-skip and busy behaviour:
  - ZERO_SKIP=1, a=0, b=0x12345678 -> result=0, out_valid high 1 cycle after accept.
  - ZERO_SKIP=0, same stimulus -> result=0 after 18 cycles.
  - Check in_ready=0 throughout the operation.
- Backpressure then reset:
  - Hold out_ready=0 for 10 cycles in DONE -> result and out_valid are stable.
  - Then assert rst for 1 cycle mid-CALC of the next op -> out_valid=0 and in_ready=1 the cycle after rst deasserts; no stale result emitted.
- WIDTH=8 random sweep, 1000 ops, mixed is_signed and random out_ready stalls -> every result matches the reference product modulo 2^16, in order.
